// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - lsu_state_e : FSM states of load_store_unit
//   - DEF_*       : default RAM / MMIO window constants and MMIO timeout
//   - F3_*        : RISC-V funct3 encodings for loads and stores
//   - lsu_fault_e : reason a request is refused
//   - fault_cause : classifies a request (fn3 legality, alignment, window)
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_ACC,
    S_RAM_RSP,
    S_MMIO_WAIT,
    S_MMIO_RSP,
    S_FAULT
  } lsu_state_e;

  localparam logic [31:0] DEF_RAM_BASE     = 32'h8000_2000;
  localparam logic [31:0] DEF_RAM_BYTES    = 32'd32768;
  localparam logic [31:0] DEF_MMIO_BASE    = 32'h1000_0000;
  localparam logic [31:0] DEF_MMIO_BYTES   = 32'd4096;
  localparam int unsigned DEF_MMIO_TIMEOUT = 255;

  // funct3 encodings. fn3[1:0] is the access size for both loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    FC_NONE,
    FC_BAD_FN3,
    FC_MISALIGN,
    FC_NO_WINDOW
  } lsu_fault_e;

  // Returns the first reason the request cannot be performed, FC_NONE if legal.
  function automatic lsu_fault_e fault_cause(input logic       we,
                                             input logic [2:0] fn3,
                                             input logic [1:0] addr_lo,
                                             input logic       in_window);
    logic bad_fn3;
    logic misalign;
    if (we) bad_fn3 = (fn3 > F3_W);
    else    bad_fn3 = (fn3 == 3'b011) || (fn3[2:1] == 2'b11);
    misalign = ((fn3[1:0] == 2'b01) && addr_lo[0]) ||
               ((fn3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (bad_fn3)         return FC_BAD_FN3;
    else if (misalign)   return FC_MISALIGN;
    else if (!in_window) return FC_NO_WINDOW;
    else                 return FC_NONE;
  endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational request classifier for the load/store unit.
//   addr, we, fn3 : request being offered
//   ram_hit       : addr lies in [RAM_BASE, RAM_BASE+RAM_BYTES)
//   mmio_hit      : addr lies in [MMIO_BASE, MMIO_BASE+MMIO_BYTES)
//   fault         : request is illegal (bad fn3, misaligned, or no window)
module lsu_addr_decode
  import lsu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter logic [31:0] RAM_BYTES  = DEF_RAM_BYTES,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_BYTES = DEF_MMIO_BYTES
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [2:0]  fn3,
  output logic        ram_hit,
  output logic        mmio_hit,
  output logic        fault
);

  logic [31:0] ram_off;
  logic [31:0] mmio_off;

  // Compare offsets rather than BASE+BYTES so a window touching 2^32 cannot wrap.
  assign ram_off  = addr - RAM_BASE;
  assign mmio_off = addr - MMIO_BASE;
  assign ram_hit  = (addr >= RAM_BASE)  && (ram_off  < RAM_BYTES);
  assign mmio_hit = (addr >= MMIO_BASE) && (mmio_off < MMIO_BYTES);
  assign fault    = (fault_cause(we, fn3, addr[1:0], ram_hit | mmio_hit) != FC_NONE);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: routes one request at a time to data RAM or MMIO,
// refusing illegal requests with a fault response.
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : request in (valid/ready), addr/wdata/we/fn3
//   resp_*                   : one-cycle response pulse, rdata and fault
//   ram_*                    : data-RAM port, read data one cycle after address
//   mmio_*                   : MMIO port, valid held until ack or timeout
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle. Responses carry no
// ready and are always taken; resp_fault/resp_rdata are 0 when resp_valid=0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE     = DEF_RAM_BASE,
  parameter logic [31:0] RAM_BYTES    = DEF_RAM_BYTES,
  parameter logic [31:0] MMIO_BASE    = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_BYTES   = DEF_MMIO_BYTES,
  parameter int unsigned MMIO_TIMEOUT = DEF_MMIO_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [2:0]  ram_fn3,
  input  logic [31:0] ram_rdata,
  output logic        mmio_valid,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic        mmio_we,
  output logic [2:0]  mmio_fn3,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata
);

  // Counter value seen on the last allowed wait cycle (MMIO_TIMEOUT >= 1 assumed).
  localparam logic [31:0] TIMEOUT_LAST = 32'(MMIO_TIMEOUT - 1);

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  fn3_q;
  logic        ram_we_q;
  logic        mmio_valid_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] mmio_data_q;
  logic [31:0] wait_cnt;

  logic dec_ram_hit;
  logic dec_mmio_hit;
  logic dec_fault;
  logic accept;

  lsu_addr_decode #(
    .RAM_BASE   (RAM_BASE),
    .RAM_BYTES  (RAM_BYTES),
    .MMIO_BASE  (MMIO_BASE),
    .MMIO_BYTES (MMIO_BYTES)
  ) u_decode (
    .addr     (req_addr),
    .we       (req_we),
    .fn3      (req_fn3),
    .ram_hit  (dec_ram_hit),
    .mmio_hit (dec_mmio_hit),
    .fault    (dec_fault)
  );

  assign accept = req_valid && req_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      fn3_q        <= '0;
      ram_we_q     <= 1'b0;
      mmio_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      mmio_data_q  <= '0;
      wait_cnt     <= '0;
    end else begin
      // Pulsed outputs default low; mmio_data_q is only non-zero in MMIO_RSP.
      ram_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      mmio_data_q  <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            we_q        <= req_we;
            fn3_q       <= req_fn3;
            wait_cnt    <= '0;
            req_ready_q <= 1'b0;
            if (dec_fault) begin
              state        <= S_FAULT;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else if (dec_ram_hit) begin
              state    <= S_RAM_ACC;
              ram_we_q <= req_we;
            end else begin
              state        <= S_MMIO_WAIT;
              mmio_valid_q <= 1'b1;
            end
          end
        end
        S_RAM_ACC: begin
          state        <= S_RAM_RSP;
          resp_valid_q <= 1'b1;
        end
        S_MMIO_WAIT: begin
          // Ack wins over timeout when both land on the same edge.
          if (mmio_ack) begin
            state        <= S_MMIO_RSP;
            mmio_valid_q <= 1'b0;
            resp_valid_q <= 1'b1;
            mmio_data_q  <= we_q ? 32'd0 : mmio_rdata;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state        <= S_FAULT;
            mmio_valid_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RAM_RSP, S_MMIO_RSP, S_FAULT: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          mmio_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  // RAM read data arrives during RAM_RSP, so it is passed straight through.
  assign resp_rdata = (state == S_RAM_RSP && !we_q) ? ram_rdata : mmio_data_q;

  // Latched request fields stay on both ports until the next accept; the RAM
  // formats load data using ram_fn3 during RAM_RSP.
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_fn3    = fn3_q;
  assign ram_we     = ram_we_q;
  assign mmio_valid = mmio_valid_q;
  assign mmio_addr  = addr_q;
  assign mmio_wdata = wdata_q;
  assign mmio_we    = we_q;
  assign mmio_fn3   = fn3_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_fn3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [2:0]  ram_fn3;
  logic [31:0] ram_rdata;
  logic        mmio_valid;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_we;
  logic [2:0]  mmio_fn3;
  logic        mmio_ack;
  logic [31:0] mmio_rdata;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_fn3    (req_fn3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_fn3    (ram_fn3),
    .ram_rdata  (ram_rdata),
    .mmio_valid (mmio_valid),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_we    (mmio_we),
    .mmio_fn3   (mmio_fn3),
    .mmio_ack   (mmio_ack),
    .mmio_rdata (mmio_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- RAM model: word array, 1-cycle read latency ----------------
  logic [31:0] mem [0:8191];
  logic [31:0] ram_off;
  assign ram_off = ram_addr - 32'h8000_2000;

  always @(posedge clk) begin
    if (ram_we) mem[ram_off[14:2]] <= ram_wdata;
    ram_rdata <= mem[ram_off[14:2]];
  end

  // ---------------- MMIO responder: ack on the ack_dly-th valid cycle ----------------
  int          ack_dly  = 0;   // 0 = never acknowledge
  logic [31:0] ack_data = '0;
  int          mcnt     = 0;

  always @(negedge clk) begin
    if (mmio_valid) begin
      mcnt++;
      mmio_ack   = (ack_dly != 0) && (mcnt == ack_dly);
      mmio_rdata = ack_data;
    end else begin
      mcnt       = 0;
      mmio_ack   = 1'b0;
      mmio_rdata = '0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  fn3;
    int          ack_dly;
    logic [31:0] ack_data;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat;     // negedges after the accept edge until resp_valid
    int          exp_ram_we;  // ram_we cycles seen
    int          exp_mmio;    // mmio_valid cycles seen
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic we, input logic [2:0] fn3,
                              input int ack_dly_i, input logic [31:0] ack_data_i,
                              input logic exp_fault, input logic [31:0] exp_rdata,
                              input int exp_lat, input int exp_ram_we, input int exp_mmio);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.we = we; v.fn3 = fn3;
    v.ack_dly = ack_dly_i; v.ack_data = ack_data_i;
    v.exp_fault = exp_fault; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    v.exp_ram_we = exp_ram_we; v.exp_mmio = exp_mmio;
    return v;
  endfunction

  // ---------------- driver: one transaction, started and ended on a negedge ----------------
  task automatic run_vec(input vec_t v, input int k);
    int          lat;
    int          rw;
    int          mm;
    int          waitc;
    logic        f;
    logic [31:0] rd;
    ack_dly  = v.ack_dly;
    ack_data = v.ack_data;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check($sformatf("v%0d_ready", k), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_we    = v.we;
    req_fn3   = v.fn3;
    @(posedge clk);
    lat = 0; rw = 0; mm = 0; f = 1'b0; rd = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ram_we) rw++;
      if (mmio_valid) mm++;
      if (resp_valid) begin
        lat = i;
        f   = resp_fault;
        rd  = resp_rdata;
        break;
      end
    end
    @(negedge clk);
    if (ram_we) rw++;
    if (mmio_valid) mm++;
    check($sformatf("v%0d_lat", k), lat, v.exp_lat);
    check($sformatf("v%0d_fault", k), {31'd0, f}, {31'd0, v.exp_fault});
    check($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
    check($sformatf("v%0d_ram_we_cycles", k), rw, v.exp_ram_we);
    check($sformatf("v%0d_mmio_cycles", k), mm, v.exp_mmio);
    check($sformatf("v%0d_resp_idle", k), {30'd0, resp_valid, resp_fault} | resp_rdata, 32'd0);
  endtask

  // ---------------- main ----------------
  int ready_n;
  int resp_n;
  int first_idx;
  int second_idx;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    ram_rdata = '0;
    mmio_ack  = 1'b0;
    mmio_rdata = '0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0; req_wdata = '0; req_we = 1'b0; req_fn3 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_mmio_valid", {31'd0, mmio_valid}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);

    //              addr          wdata         we  fn3     ack  ack_data      flt rdata         lat  rw mm
    vecs[0]  = mk(32'h8000_2004, 32'hDEAD_BEEF, 1, 3'b010,   0, 32'h0,          0, 32'h0,          2, 1, 0);
    vecs[1]  = mk(32'h8000_2004, 32'h0,         0, 3'b010,   0, 32'h0,          0, 32'hDEAD_BEEF,  2, 0, 0);
    vecs[2]  = mk(32'h8000_2001, 32'h0,         0, 3'b001,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[3]  = mk(32'h1000_0010, 32'h0,         0, 3'b010,   3, 32'h0000_0041,  0, 32'h0000_0041,  4, 0, 3);
    vecs[4]  = mk(32'h8000_A000, 32'h0,         0, 3'b010,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[5]  = mk(32'h0000_0000, 32'h0,         0, 3'b010,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[6]  = mk(32'h8000_9FFC, 32'h1234_5678, 1, 3'b010,   0, 32'h0,          0, 32'h0,          2, 1, 0);
    vecs[7]  = mk(32'h8000_9FFC, 32'h0,         0, 3'b010,   0, 32'h0,          0, 32'h1234_5678,  2, 0, 0);
    vecs[8]  = mk(32'h8000_2002, 32'h0,         0, 3'b010,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[9]  = mk(32'h8000_2000, 32'h0,         0, 3'b011,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[10] = mk(32'h8000_2000, 32'h5555_5555, 1, 3'b100,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[11] = mk(32'h1000_1000, 32'h0,         0, 3'b010,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[12] = mk(32'h1000_0FFC, 32'hA5A5_0001, 1, 3'b010,   1, 32'h0000_FFFF,  0, 32'h0,          2, 0, 1);
    vecs[13] = mk(32'h8000_2007, 32'h0,         0, 3'b100,   0, 32'h0,          0, 32'hDEAD_BEEF,  2, 0, 0);
    vecs[14] = mk(32'h8000_2003, 32'h0,         0, 3'b101,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[15] = mk(32'h1000_0020, 32'h0,         0, 3'b010,   0, 32'h0,          1, 32'h0,        256, 0, 255);
    vecs[16] = mk(32'h1000_0024, 32'h0,         0, 3'b010, 255, 32'hCAFE_0001,  0, 32'hCAFE_0001,256, 0, 255);
    vecs[17] = mk(32'h0FFF_FFFE, 32'h0,         0, 3'b001,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[18] = mk(32'h8000_1FFF, 32'h0,         0, 3'b000,   0, 32'h0,          1, 32'h0,          1, 0, 0);
    vecs[19] = mk(32'h1000_0000, 32'h0,         0, 3'b000,   2, 32'h0000_007F,  0, 32'h0000_007F,  3, 0, 2);

    for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

    // Back-to-back RAM loads: one accept every 3 cycles.
    ack_dly = 0;
    req_valid = 1'b1;
    req_addr  = 32'h8000_2004;
    req_we    = 1'b0;
    req_fn3   = 3'b010;
    ready_n = 0; resp_n = 0; first_idx = -1; second_idx = -1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) begin
        ready_n++;
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) second_idx = i;
      end
      if (resp_valid) begin
        resp_n++;
        check($sformatf("b2b_rdata_%0d", i), resp_rdata, 32'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", ready_n, 32'd3);
    check("b2b_spacing", second_idx - first_idx, 32'd3);
    check("b2b_resps", resp_n, 32'd3);
    repeat (3) @(negedge clk);

    // Reset while waiting on MMIO: valid drops, no response, ready next cycle.
    ack_dly = 0;
    req_valid = 1'b1;
    req_addr  = 32'h1000_0030;
    req_we    = 1'b0;
    req_fn3   = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_pre_valid", {31'd0, mmio_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_mmio_valid", {31'd0, mmio_valid}, 32'd0);
    check("mrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    resp_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || mmio_valid) resp_n++;
    end
    check("mrst_no_resp", resp_n, 32'd0);

    // Reset while in RAM_ACC: ram_we inhibited from the reset edge.
    req_valid = 1'b1;
    req_addr  = 32'h8000_2008;
    req_wdata = 32'h0000_0055;
    req_we    = 1'b1;
    req_fn3   = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rrst_pre_we", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rrst_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || ram_we) resp_n++;
    end
    check("rrst_no_activity", resp_n, 32'd0);
    check("rrst_req_ready", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
